regfile_wb_scheduler: RTL and testbench

// Shares the register file's single write port (we3/addr3/writeData3) between N_REQ writeback requesters
//   (req 0 = single-cycle ALU path, req 1 = multi-cycle mul/div unit).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 33 +++
 rtl/regfile_wb_scheduler.sv | 116 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Register file geometry and helpers shared by the
// writeback scheduler and its arbiter.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr
// wins; grant is one-hot or zero.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the regfile write port among writeback requesters
// and tracks pending destinations to stall dependent reads.
module regfile_wb_scheduler #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    rsv_valid,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic [ADDR_W-1:0]       chk_addr1,
  input  logic [ADDR_W-1:0]       chk_addr2,
  output logic                    stall,
  output logic                    we3,
  output logic [ADDR_W-1:0]       addr3,
  output logic [DATA_W-1:0]       writeData3,
  output logic                    err_double_rsv
);
  import regfile_pkg::*;

  localparam int IDX_W = idx_w(N_REQ);
  localparam int NREG  = 1 << ADDR_W;

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] addr3_q, addr3_d;
  logic [DATA_W-1:0] data3_q, data3_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              xfer;
  logic              rsv_set;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt & {N_REQ{rst_n}};
  assign xfer      = gnt_any & rst_n;
  assign win_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign win_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign rsv_set   = rsv_valid && (rsv_addr != '0);

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (int'(gnt_idx) == N_REQ - 1)
        ptr_d = '0;
      else
        ptr_d = gnt_idx + IDX_W'(1);
    end
  end

  // writes to r0 are accepted but never reach the regfile
  always_comb begin
    we3_d   = xfer && (win_addr != '0);
    addr3_d = we3_d ? win_addr : addr3_q;
    data3_d = we3_d ? win_data : data3_q;
  end

  // clear first so a same-edge reserve wins
  always_comb begin
    pend_d = pend_q;
    if (we3_q)
      pend_d[addr3_q] = 1'b0;
    if (rsv_set)
      pend_d[rsv_addr] = 1'b1;
    pend_d[0] = 1'b0;
    err_d = err_q;
    if (rsv_set && pend_q[rsv_addr]
        && !(we3_q && addr3_q == rsv_addr))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      we3_q   <= 1'b0;
      addr3_q <= '0;
      data3_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      we3_q   <= we3_d;
      addr3_q <= addr3_d;
      data3_q <= data3_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign stall          = pend_q[chk_addr1] | pend_q[chk_addr2];
  assign we3            = we3_q;
  assign addr3          = addr3_q;
  assign writeData3     = data3_q;
  assign err_double_rsv = err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a write
// scoreboard and a small pending-bitmap model.
module tb_regfile_wb_scheduler;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic          rsv_valid;
  logic [AW-1:0] rsv_addr;
  logic [AW-1:0] chk_addr1;
  logic [AW-1:0] chk_addr2;
  logic          stall;
  logic          we3;
  logic [AW-1:0] addr3;
  logic [DW-1:0] writeData3;
  logic          err_double_rsv;

  regfile_wb_scheduler #(
    .N_REQ  (N),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rsv_valid      (rsv_valid),
    .rsv_addr       (rsv_addr),
    .chk_addr1      (chk_addr1),
    .chk_addr2      (chk_addr2),
    .stall          (stall),
    .we3            (we3),
    .addr3          (addr3),
    .writeData3     (writeData3),
    .err_double_rsv (err_double_rsv)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int errs   = 0;
  int checks = 0;

  wr_t        exp_q[$];
  logic [N-1:0] glog[$];
  int         m_ptr;
  logic       m_we;
  logic [31:0] m_pend;
  logic       m_err;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_pend = '0;
    m_err  = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_req(int i, logic v,
                         logic [AW-1:0] a,
                         logic [DW-1:0] d);
    req_valid[i]       = v;
    req_addr[i*AW+:AW] = a;
    req_data[i*DW+:DW] = d;
  endtask

  task automatic tick();
    logic [N-1:0]  g;
    logic [31:0]   np;
    logic [AW-1:0] wa;
    logic [AW-1:0] ga;
    wr_t           w;
    int            idx;
    int            gi;
    @(negedge clk);
    g  = '0;
    gi = -1;
    wa = '0;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (req_valid[idx] && gi < 0) begin
          g[idx] = 1'b1;
          gi     = idx;
        end
      end
    end
    chk("ready", 64'(req_ready), 64'(g));
    chk("we3", 64'(we3), 64'(m_we));
    if (m_we) begin
      if (exp_q.size() > 0) begin
        w  = exp_q.pop_front();
        wa = w.a;
        chk("addr3", 64'(addr3), 64'(w.a));
        chk("wdata3", 64'(writeData3), 64'(w.d));
      end else begin
        checks++;
        errs++;
        $error("FAIL sb_empty observed=we3 expected=none");
      end
    end
    chk("stall", 64'(stall),
        64'(m_pend[chk_addr1] | m_pend[chk_addr2]));
    chk("err", 64'(err_double_rsv), 64'(m_err));
    if (rst_n) begin
      np = m_pend;
      if (m_we) np[wa] = 1'b0;
      if (rsv_valid && rsv_addr != '0) begin
        if (m_pend[rsv_addr] && !(m_we && wa == rsv_addr))
          m_err = 1'b1;
        np[rsv_addr] = 1'b1;
      end
      m_pend = np;
      m_we   = 1'b0;
      if (gi >= 0) begin
        ga = req_addr[gi*AW+:AW];
        if (ga != '0) begin
          exp_q.push_back({ga, req_data[gi*DW+:DW]});
          m_we = 1'b1;
        end
        m_ptr = (gi + 1) % N;
      end
    end
    glog.push_back(g);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    chk_addr1 = '0;
    chk_addr2 = '0;
    model_reset();
    set_req(0, 1'b1, 5'd4, 32'h55);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_we3", 64'(we3), 64'(0));
    chk("rst_addr3", 64'(addr3), 64'(0));
    chk("rst_wdata3", 64'(writeData3), 64'(0));
    chk("rst_err", 64'(err_double_rsv), 64'(0));
    set_req(0, 1'b0, '0, '0);
    rst_n = 1'b1;
    tick();

    // reset lands while a write is in flight
    set_req(0, 1'b1, 5'd5, 32'h1234);
    tick();
    set_req(0, 1'b0, '0, '0);
    chk("mid_we3_pre", 64'(we3), 64'(1));
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_we3", 64'(we3), 64'(0));
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // contention
    glog.delete();
    set_req(0, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 5'd2, 32'hB);
    repeat (4) tick();
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    chk("cont_g0", 64'(glog[0]), 64'(2'b01));
    chk("cont_g1", 64'(glog[1]), 64'(2'b10));
    chk("cont_g2", 64'(glog[2]), 64'(2'b01));
    chk("cont_g3", 64'(glog[3]), 64'(2'b10));
    tick();

    // reserve r7, written by the mul/div path
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    tick();
    rsv_valid = 1'b0;
    chk_addr1 = 5'd7;
    #1;
    chk("sb_stall", 64'(stall), 64'(1));
    tick();
    set_req(1, 1'b1, 5'd7, 32'hCAFE);
    tick();
    set_req(1, 1'b0, '0, '0);
    #1;
    chk("sb_we3", 64'(we3), 64'(1));
    chk("sb_stall_we3", 64'(stall), 64'(1));
    tick();
    chk("sb_stall_after", 64'(stall), 64'(0));
    chk_addr1 = '0;
    tick();

    // reserve r9 again on the edge its write commits
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    tick();
    rsv_valid = 1'b0;
    set_req(0, 1'b1, 5'd9, 32'h99);
    tick();
    set_req(0, 1'b0, '0, '0);
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    tick();
    rsv_valid = 1'b0;
    chk_addr1 = 5'd9;
    #1;
    chk("race_pend", 64'(stall), 64'(1));
    chk("race_err", 64'(err_double_rsv), 64'(0));
    set_req(0, 1'b1, 5'd9, 32'h9A);
    tick();
    set_req(0, 1'b0, '0, '0);
    tick();
    chk("race_clr", 64'(stall), 64'(0));
    chk_addr1 = '0;

    // double reserve of r3
    rsv_valid = 1'b1;
    rsv_addr  = 5'd3;
    repeat (2) tick();
    rsv_valid = 1'b0;
    chk("dbl_err", 64'(err_double_rsv), 64'(1));
    repeat (2) tick();
    chk("dbl_sticky", 64'(err_double_rsv), 64'(1));

    // zero register
    set_req(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    chk("zero_ready", 64'(req_ready[0]), 64'(1));
    tick();
    set_req(0, 1'b0, '0, '0);
    chk("zero_we3", 64'(we3), 64'(0));
    rsv_valid = 1'b1;
    rsv_addr  = 5'd0;
    tick();
    rsv_valid = 1'b0;
    chk_addr1 = '0;
    chk_addr2 = '0;
    #1;
    chk("zero_stall", 64'(stall), 64'(0));

    // second read port
    rsv_valid = 1'b1;
    rsv_addr  = 5'd12;
    tick();
    rsv_valid = 1'b0;
    chk_addr2 = 5'd12;
    #1;
    chk("chk2_stall", 64'(stall), 64'(1));
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
